// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_pkg
//  Purpose  : Shared AXI4-Lite types: the response code enum and the state
//             encoding of the read-channel slave FSM.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package axi4_lite_pkg;

    // AXI response codes as carried on RRESP/BRESP.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Read-slave FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } rd_state_t;

endpackage : axi4_lite_pkg
`default_nettype wire

// File: rtl/axi4_lite_slave_read_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_slave_read_if
//  Purpose  : Bundles the AXI4-Lite read channels (AR, R) and the user
//             register-file read port of the read slave.
//  Ports    : AR channel  ARVALID, ARREADY, ARADDR, ARPROT
//             R channel   RVALID, RREADY, RDATA, RRESP
//             reg port    REG_RD_EN, REG_RD_IDX, REG_RD_DATA
//             modport slave  : the read slave (drives ARREADY, R, reg strobe)
//             modport master : the bus master plus the register file
//  Revision : 1.0  initial release
// ============================================================================
interface axi4_lite_slave_read_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;

    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;

    logic                  REG_RD_EN;
    logic [IDX_W-1:0]      REG_RD_IDX;
    logic [DATA_WIDTH-1:0] REG_RD_DATA;

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY, REG_RD_DATA,
        output ARREADY, RVALID, RDATA, RRESP, REG_RD_EN, REG_RD_IDX
    );

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY, REG_RD_DATA,
        input  ARREADY, RVALID, RDATA, RRESP, REG_RD_EN, REG_RD_IDX
    );

endinterface : axi4_lite_slave_read_if
`default_nettype wire

// File: rtl/axi4_lite_slave_read.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_slave_read
//  Purpose  : AXI4-Lite read-channel slave. Accepts one AR request at a time,
//             reads one word from a fixed-latency register file and returns
//             it on R. Addresses beyond the register window get SLVERR
//             without touching the register file.
//  Params   : ADDR_WIDTH  AR address width
//             DATA_WIDTH  word width, 32 or 64
//             NUM_REGS    registers behind the port, power of two, >= 2
//             RD_LATENCY  cycles from REG_RD_EN to REG_RD_DATA valid, >= 1
//  Ports    : ACLK    clock, rising edge
//             ARESET  asynchronous active-high reset
//             bus     axi4_lite_slave_read_if.slave (AR, R, register port)
//  Revision : 1.0  initial release
// ============================================================================
module axi4_lite_slave_read
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    axi4_lite_slave_read_if.slave        bus
);

    localparam int IDX_W   = $clog2(NUM_REGS);
    // Byte-offset bits within one word: 2 for 32-bit, 3 for 64-bit words.
    localparam int IDX_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_MSB = IDX_LSB + IDX_W - 1;
    localparam int CNT_W   = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] C_LATENCY = CNT_W'(RD_LATENCY);

    rd_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    resp_t                 r_rresp;
    logic                  r_rd_en;
    logic [IDX_W-1:0]      r_rd_idx;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_in_range;
    logic                  w_unused_ok;

    assign w_idx      = bus.ARADDR[IDX_MSB:IDX_LSB];
    assign w_in_range = (bus.ARADDR[ADDR_WIDTH-1:IDX_MSB+1] == '0);

    // Protection bits and the byte offset carry no meaning for this slave.
    assign w_unused_ok = &{1'b0, bus.ARPROT, bus.ARADDR[IDX_LSB-1:0]};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
            r_rd_en   <= 1'b0;
            r_rd_idx  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // ARREADY comes up one edge after reset release; on the
                    // return from RESP it is already set.
                    if (!r_arready) begin
                        r_arready <= 1'b1;
                    end else if (bus.ARVALID) begin
                        r_arready <= 1'b0;
                        if (w_in_range) begin
                            r_state  <= FETCH;
                            r_rd_en  <= 1'b1;
                            r_rd_idx <= w_idx;
                            r_cnt    <= C_LATENCY;
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end

                FETCH: begin
                    r_rd_en <= 1'b0;
                    // The strobe is seen by the register file at the first
                    // FETCH edge; data is then valid RD_LATENCY edges later.
                    if (r_cnt == '0) begin
                        r_rdata  <= bus.REG_RD_DATA;
                        r_rresp  <= OKAY;
                        r_rvalid <= 1'b1;
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                RESP: begin
                    // Entering RESP with RVALID low means the address missed
                    // the register window: raise the error one edge later.
                    if (!r_rvalid) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= '0;
                        r_rresp  <= SLVERR;
                    end else if (bus.RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ARREADY    = r_arready;
    assign bus.RVALID     = r_rvalid;
    assign bus.RDATA      = r_rdata;
    assign bus.RRESP      = r_rresp;
    assign bus.REG_RD_EN  = r_rd_en;
    assign bus.REG_RD_IDX = r_rd_idx;

endmodule : axi4_lite_slave_read
`default_nettype wire
